mem_bist: RTL and testbench
===========================

MEM_BIST -- requirements
Module: mem_bist

Interface
REQ-001 SHALL have parameter wordSize, default 8: data width; it SHALL match the attached memory's wordSize.
REQ-002 SHALL have parameter addressSize, default 3: address bits; N = 2^addressSize locations are tested.
REQ-003 CLK  input  1: single clock; all state SHALL update on its rising edge only.
REQ-004 RST  input  1: reset, synchronous, active-high.
REQ-005 START  input  1: start request, sampled only in IDLE.
REQ-006 PATTERN  input  wordSize: test word P, captured on the edge that accepts START.
REQ-007 MEM_ADDR  output  addressSize: registered address to the memory ADDR port.
REQ-008 MEM_DIN  output  wordSize: registered write data to the memory DIN port.
REQ-009 MEM_DOUT  input  wordSize: read data from the memory DOUT port.
REQ-010 BUSY  output  1: high while a test runs.
REQ-011 DONE  output  1: one-cycle completion pulse.
REQ-012 FAIL  output  1: sticky mismatch flag; valid when DONE is high.
REQ-013 FAIL_ADDR  output  addressSize: address of the first mismatch.
REQ-014 ERR_COUNT  output  addressSize+2: mismatch count, saturating at all-ones.

Function
REQ-015 Memory model: the attached memory writes DIN to mem[ADDR] and loads the old mem[ADDR] into DOUT on every rising edge, so each access is a read-then-write.
REQ-016 FSM states SHALL be IDLE, FILL, PASS_A, PASS_B and DRAIN.
REQ-017 IDLE SHALL go to FILL on the edge where START=1; that edge SHALL capture P, launch MEM_ADDR=0, set BUSY=1, clear FAIL and ERR_COUNT, and set FAIL_ADDR=0.
REQ-018 FILL SHALL drive MEM_DIN=P for addresses 0..N-1, one per cycle, with compare disabled.
REQ-019 PASS_A SHALL drive MEM_DIN=~P for addresses 0..N-1, with expected data P.
REQ-020 PASS_B SHALL drive MEM_DIN=P for addresses 0..N-1, with expected data ~P.
REQ-021 MEM_ADDR SHALL wrap from N-1 to 0 at each pass boundary, with no idle cycle between passes.
REQ-022 Timing: the address launched at edge t is captured by the memory at edge t+1; MEM_DOUT SHALL be compared at edge t+2, using a 2-stage pipeline of {valid, address, expected} that is independent of FSM state.
REQ-023 Edge 3N SHALL enter DRAIN; DRAIN SHALL hold MEM_ADDR=N-1 and MEM_DIN=P for 2 cycles, during which the final compare occurs at edge 3N+1.
REQ-024 Edge 3N+2 SHALL return to IDLE, drive BUSY=0, and drive DONE=1 for exactly one cycle.
REQ-025 On a mismatch: ERR_COUNT SHALL increment, saturating; FAIL SHALL set; FAIL_ADDR SHALL load only on the first mismatch of the run.
REQ-026 START SHALL be ignored when not in IDLE.
REQ-027 START held high SHALL restart the test on the edge after the DONE pulse (back-to-back runs).
REQ-028 In IDLE, MEM_ADDR and MEM_DIN SHALL hold their last values.
REQ-029 FAIL, FAIL_ADDR and ERR_COUNT SHALL hold their values until the next accepted START.

Reset
REQ-030 RST=1 SHALL, on the next edge, force IDLE and clear all pipeline valid bits.
REQ-031 RST=1 SHALL drive MEM_ADDR=0, MEM_DIN=0, BUSY=0, DONE=0, FAIL=0, FAIL_ADDR=0, ERR_COUNT=0, and P=0.
REQ-032 RST SHALL take priority over START.
REQ-033 RST mid-test SHALL abort the run with no DONE pulse and no late compare.

Structure
REQ-034 A shared package (mem_bist_pkg) SHALL hold the state encoding, the compare-pipeline depth constant (2) and the DRAIN length constant (2).
REQ-035 The compare pipeline and error accounting SHALL be one sub-module, mem_bist_cmp.
REQ-036 The bench SHALL connect mem_bist to the memory block with matching parameters.

Verification (wordSize=8, addressSize=3, N=8, START accepted at edge 0)
REQ-037 Fault-free memory, PATTERN=8'hA5 -> DONE pulse at edge 26; FAIL=0; ERR_COUNT=0.
REQ-038 DOUT bit0 forced to 0 when reading address 5, PATTERN=8'hA5 -> FAIL=1; FAIL_ADDR=5; ERR_COUNT=1 (PASS_A mismatch only).
REQ-039 All DOUT bits forced to 0, PATTERN=8'hFF -> FAIL=1; FAIL_ADDR=0; ERR_COUNT=8 (every PASS_A read fails; PASS_B expects 0, matches).
REQ-040 RST pulsed at edge 12 (inside PASS_A) -> IDLE with all outputs 0 after edge 13; no DONE pulse.
REQ-041 START re-asserted at edge 5 -> ignored; DONE still at edge 26.
REQ-042 START held high, PATTERN=8'h00 -> second DONE at edge 53; FAIL=0 both runs.
REQ-043 The bench SHALL check MEM_ADDR wrap 7->0 at edges 8 and 16.

Source files
------------

// File: rtl/mem_bist_pkg.sv
// rtl/mem_bist_pkg.sv - shared state encoding and pipeline constants for mem_bist
package mem_bist_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        PASS_A,
        PASS_B,
        DRAIN
    } state_e;

    localparam int CMP_DEPTH = 2;
    localparam int DRAIN_LEN = 2;

    // Drain counter value on the cycle that returns to IDLE
    localparam logic [1:0] DRAIN_LAST = 2'(DRAIN_LEN - 1);

endpackage

// File: rtl/mem_bist_if.sv
// rtl/mem_bist_if.sv - memory-side bus between mem_bist and the single-port memory
interface mem_bist_if #(
    parameter int wordSize    = 8,
    parameter int addressSize = 3
);
    logic [addressSize-1:0] MEM_ADDR;
    logic [wordSize-1:0]    MEM_DIN;
    logic [wordSize-1:0]    MEM_DOUT;

    modport master (output MEM_ADDR, output MEM_DIN, input MEM_DOUT);
    modport slave  (input MEM_ADDR, input MEM_DIN, output MEM_DOUT);
endinterface

// File: rtl/mem_bist_cmp.sv
// rtl/mem_bist_cmp.sv - two-stage compare pipeline and mismatch accounting
module mem_bist_cmp
    import mem_bist_pkg::*;
#(
    parameter int wordSize    = 8,
    parameter int addressSize = 3
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   clear_i,
    input  logic                   launch_vld_i,
    input  logic [addressSize-1:0] launch_addr_i,
    input  logic [wordSize-1:0]    launch_exp_i,
    input  logic [wordSize-1:0]    dout_i,
    output logic                   fail_o,
    output logic [addressSize-1:0] fail_addr_o,
    output logic [addressSize+1:0] err_count_o
);

    logic                   vld_q  [CMP_DEPTH];
    logic [addressSize-1:0] addr_q [CMP_DEPTH];
    logic [wordSize-1:0]    exp_q  [CMP_DEPTH];

    logic                   fail_q, fail_d;
    logic [addressSize-1:0] fail_addr_q, fail_addr_d;
    logic [addressSize+1:0] err_q, err_d;
    logic                   mismatch;

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < CMP_DEPTH; i++) begin
                vld_q[i]  <= 1'b0;
                addr_q[i] <= '0;
                exp_q[i]  <= '0;
            end
        end else begin
            vld_q[0]  <= launch_vld_i;
            addr_q[0] <= launch_addr_i;
            exp_q[0]  <= launch_exp_i;
            for (int i = 1; i < CMP_DEPTH; i++) begin
                vld_q[i]  <= vld_q[i-1];
                addr_q[i] <= addr_q[i-1];
                exp_q[i]  <= exp_q[i-1];
            end
        end
    end

    // The last stage lines up with the memory's registered read data
    assign mismatch = vld_q[CMP_DEPTH-1] && (dout_i != exp_q[CMP_DEPTH-1]);

    always_comb begin
        fail_d      = fail_q;
        fail_addr_d = fail_addr_q;
        err_d       = err_q;
        if (clear_i) begin
            fail_d      = 1'b0;
            fail_addr_d = '0;
            err_d       = '0;
        end else if (mismatch) begin
            fail_d = 1'b1;
            if (!fail_q) fail_addr_d = addr_q[CMP_DEPTH-1];
            if (err_q != '1) err_d = err_q + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
            err_q       <= '0;
        end else begin
            fail_q      <= fail_d;
            fail_addr_q <= fail_addr_d;
            err_q       <= err_d;
        end
    end

    assign fail_o      = fail_q;
    assign fail_addr_o = fail_addr_q;
    assign err_count_o = err_q;

endmodule

// File: rtl/mem_bist.sv
// rtl/mem_bist.sv - fill / invert / restore march BIST for a read-then-write memory
module mem_bist
    import mem_bist_pkg::*;
#(
    parameter int wordSize    = 8,
    parameter int addressSize = 3
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   START,
    input  logic [wordSize-1:0]    PATTERN,
    mem_bist_if.master             mem,
    output logic                   BUSY,
    output logic                   DONE,
    output logic                   FAIL,
    output logic [addressSize-1:0] FAIL_ADDR,
    output logic [addressSize+1:0] ERR_COUNT
);

    localparam logic [addressSize-1:0] LAST_ADDR = '1;

    state_e                 state_q, state_d;
    logic [addressSize-1:0] addr_q, addr_d;
    logic [wordSize-1:0]    din_q, din_d;
    logic [wordSize-1:0]    pat_q, pat_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [1:0]             drain_q, drain_d;
    logic                   clear;
    logic                   launch_vld;
    logic [wordSize-1:0]    launch_exp;
    logic                   last;

    assign last = (addr_q == LAST_ADDR);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        din_d      = din_q;
        pat_d      = pat_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        drain_d    = drain_q;
        clear      = 1'b0;
        launch_vld = 1'b0;
        launch_exp = pat_q;
        case (state_q)
            IDLE: begin
                if (START) begin
                    state_d = FILL;
                    pat_d   = PATTERN;
                    addr_d  = '0;
                    din_d   = PATTERN;
                    busy_d  = 1'b1;
                    clear   = 1'b1;
                end
            end
            FILL: begin
                addr_d = addr_q + 1'b1;
                din_d  = pat_q;
                if (last) begin
                    state_d    = PASS_A;
                    din_d      = ~pat_q;
                    launch_vld = 1'b1;
                end
            end
            // A launch carries the expectation of the pass the new address belongs to
            PASS_A: begin
                addr_d     = addr_q + 1'b1;
                launch_vld = 1'b1;
                din_d      = ~pat_q;
                if (last) begin
                    state_d    = PASS_B;
                    din_d      = pat_q;
                    launch_exp = ~pat_q;
                end
            end
            PASS_B: begin
                din_d = pat_q;
                if (last) begin
                    state_d = DRAIN;
                    drain_d = '0;
                end else begin
                    addr_d     = addr_q + 1'b1;
                    launch_vld = 1'b1;
                    launch_exp = ~pat_q;
                end
            end
            DRAIN: begin
                drain_d = drain_q + 1'b1;
                if (drain_q == DRAIN_LAST) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            addr_q  <= '0;
            din_q   <= '0;
            pat_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            pat_q   <= pat_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            drain_q <= drain_d;
        end
    end

    mem_bist_cmp #(
        .wordSize    (wordSize),
        .addressSize (addressSize)
    ) u_cmp (
        .CLK           (CLK),
        .RST           (RST),
        .clear_i       (clear),
        .launch_vld_i  (launch_vld),
        .launch_addr_i (addr_d),
        .launch_exp_i  (launch_exp),
        .dout_i        (mem.MEM_DOUT),
        .fail_o        (FAIL),
        .fail_addr_o   (FAIL_ADDR),
        .err_count_o   (ERR_COUNT)
    );

    assign mem.MEM_ADDR = addr_q;
    assign mem.MEM_DIN  = din_q;
    assign BUSY         = busy_q;
    assign DONE         = done_q;

endmodule

// File: tb/tb_mem_bist.sv
// tb/tb_mem_bist.sv - directed bench for mem_bist with a fault-injecting memory model
module tb_mem_bist;

    logic       CLK;
    logic       RST;
    logic       START;
    logic [7:0] PATTERN;
    logic       BUSY;
    logic       DONE;
    logic       FAIL;
    logic [2:0] FAIL_ADDR;
    logic [4:0] ERR_COUNT;

    mem_bist_if #(.wordSize(8), .addressSize(3)) bus ();

    mem_bist #(
        .wordSize    (8),
        .addressSize (3)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .START     (START),
        .PATTERN   (PATTERN),
        .mem       (bus.master),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .FAIL      (FAIL),
        .FAIL_ADDR (FAIL_ADDR),
        .ERR_COUNT (ERR_COUNT)
    );

    // Read-then-write memory; fault_mode 1 clears bit0 on reads of address 5, 2 reads all zero
    logic [7:0] mem_arr [8];
    int         fault_mode;

    function automatic logic [7:0] faulty(input logic [7:0] d, input logic [2:0] a);
        if (fault_mode == 1 && a == 3'd5) return d & 8'hFE;
        if (fault_mode == 2) return 8'h00;
        return d;
    endfunction

    always_ff @(posedge CLK) begin
        bus.MEM_DOUT           <= faulty(mem_arr[bus.MEM_ADDR], bus.MEM_ADDR);
        mem_arr[bus.MEM_ADDR]  <= bus.MEM_DIN;
    end

    always #5 CLK = ~CLK;

    int n_checks;
    int n_errors;

    logic [2:0] addr_log [64];
    logic [7:0] din_log  [64];
    logic       busy_log [64];
    logic       fail_log [64];
    logic [2:0] fadr_log [64];
    logic [4:0] err_log  [64];
    logic       done_log [64];
    int         done_cnt;
    int         done_first;
    int         done_second;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic log_edge(input int e);
        addr_log[e] = bus.MEM_ADDR;
        din_log[e]  = bus.MEM_DIN;
        busy_log[e] = BUSY;
        fail_log[e] = FAIL;
        fadr_log[e] = FAIL_ADDR;
        err_log[e]  = ERR_COUNT;
        done_log[e] = DONE;
    endtask

    task automatic do_reset();
        RST   = 1'b1;
        START = 1'b0;
        @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    // Edge 0 is the edge that accepts START; edges 1..n_edges are logged after it
    task automatic run(input logic [7:0] pat, input int mode, input bit hold,
                       input int restart_at, input int rst_at, input int n_edges);
        fault_mode  = mode;
        PATTERN     = pat;
        START       = 1'b1;
        done_cnt    = 0;
        done_first  = -1;
        done_second = -1;
        @(posedge CLK);
        #1;
        log_edge(0);
        for (int e = 1; e <= n_edges; e++) begin
            START = hold || (e == restart_at);
            RST   = (e == rst_at);
            @(posedge CLK);
            #1;
            log_edge(e);
            if (DONE) begin
                if (done_cnt == 0) done_first = e;
                else if (done_cnt == 1) done_second = e;
                done_cnt++;
            end
        end
        START = 1'b0;
        RST   = 1'b0;
    endtask

    initial begin
        CLK        = 1'b0;
        RST        = 1'b1;
        START      = 1'b0;
        PATTERN    = 8'h00;
        fault_mode = 0;
        n_checks   = 0;
        n_errors   = 0;

        repeat (2) @(posedge CLK);
        #1;
        check_eq("rst_addr", bus.MEM_ADDR, 0);
        check_eq("rst_din", bus.MEM_DIN, 0);
        check_eq("rst_busy", BUSY, 0);
        check_eq("rst_done", DONE, 0);
        check_eq("rst_fail", FAIL, 0);
        check_eq("rst_fail_addr", FAIL_ADDR, 0);
        check_eq("rst_err", ERR_COUNT, 0);
        RST = 1'b0;

        // Fault-free run, pattern A5
        run(8'hA5, 0, 1'b0, 0, 0, 30);
        check_eq("ok_done_edge", done_first, 26);
        check_eq("ok_done_cnt", done_cnt, 1);
        check_eq("ok_fail", fail_log[26], 0);
        check_eq("ok_err", err_log[26], 0);
        check_eq("ok_busy1", busy_log[1], 1);
        check_eq("ok_busy25", busy_log[25], 1);
        check_eq("ok_busy26", busy_log[26], 0);
        check_eq("ok_addr7", addr_log[7], 7);
        check_eq("ok_wrap8", addr_log[8], 0);
        check_eq("ok_din8", din_log[8], 8'h5A);
        check_eq("ok_addr15", addr_log[15], 7);
        check_eq("ok_wrap16", addr_log[16], 0);
        check_eq("ok_din16", din_log[16], 8'hA5);
        check_eq("ok_drain_addr24", addr_log[24], 7);
        check_eq("ok_drain_addr25", addr_log[25], 7);
        check_eq("ok_drain_din25", din_log[25], 8'hA5);
        check_eq("ok_idle_addr28", addr_log[28], 7);
        check_eq("ok_idle_din28", din_log[28], 8'hA5);
        do_reset();

        // Stuck bit0 at address 5: only the PASS_A read mismatches
        run(8'hA5, 1, 1'b0, 0, 0, 30);
        check_eq("b0_done_edge", done_first, 26);
        check_eq("b0_fail", fail_log[26], 1);
        check_eq("b0_fail_addr", fadr_log[26], 5);
        check_eq("b0_err", err_log[26], 1);
        check_eq("b0_err14", err_log[14], 0);
        check_eq("b0_err15", err_log[15], 1);
        do_reset();

        // All reads zero with pattern FF: every PASS_A read fails
        run(8'hFF, 2, 1'b0, 0, 0, 30);
        check_eq("z_done_edge", done_first, 26);
        check_eq("z_fail", fail_log[26], 1);
        check_eq("z_fail_addr", fadr_log[26], 0);
        check_eq("z_err", err_log[26], 8);
        check_eq("z_err_hold", err_log[30], 8);
        check_eq("z_fail_hold", fail_log[30], 1);
        do_reset();

        // Reset sampled at edge 13 aborts the run
        run(8'hFF, 2, 1'b0, 0, 13, 30);
        check_eq("ab_err12", err_log[12], 3);
        check_eq("ab_addr13", addr_log[13], 0);
        check_eq("ab_din13", din_log[13], 0);
        check_eq("ab_busy13", busy_log[13], 0);
        check_eq("ab_done13", done_log[13], 0);
        check_eq("ab_fail13", fail_log[13], 0);
        check_eq("ab_fail_addr13", fadr_log[13], 0);
        check_eq("ab_err13", err_log[13], 0);
        check_eq("ab_err16", err_log[16], 0);
        check_eq("ab_done_cnt", done_cnt, 0);
        do_reset();

        // START pulsed mid-run is ignored
        run(8'hA5, 0, 1'b0, 5, 0, 30);
        check_eq("ign_done_edge", done_first, 26);
        check_eq("ign_done_cnt", done_cnt, 1);
        check_eq("ign_fail", fail_log[26], 0);
        do_reset();

        // START held high gives back-to-back runs
        run(8'h00, 0, 1'b1, 0, 0, 56);
        check_eq("b2b_done1", done_first, 26);
        check_eq("b2b_done2", done_second, 53);
        check_eq("b2b_fail1", fail_log[26], 0);
        check_eq("b2b_fail2", fail_log[53], 0);
        check_eq("b2b_busy27", busy_log[27], 1);
        check_eq("b2b_wrap35", addr_log[35], 0);
        do_reset();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
